instr_reg_ctrl: RTL and testbench

// Controller for the instruction register: shares its single write port among N_REQ

---
 rtl/instr_register_pkg.sv | 39 +++
 rtl/instr_register_inf.sv | 34 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/instr_reg_ctrl.sv | 136 +++++++++++++
 tb/tb_instr_reg_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its controller: payload format,
// slot count and the controller's sequencing states.
package instr_register_pkg;

    localparam int DEPTH = 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [3:0] {
        ZERO,
        PASSA,
        PASSB,
        ADD,
        SUB,
        MULT,
        DIV,
        MOD
    } opcode_t;

    typedef logic signed [31:0] operand_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } ctrl_state_e;

    // DEPTH is a power of two, so the natural overflow is the slot wrap.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/instr_register_inf.sv
// Connection between the instruction register storage and its controller.
// master = controller side, slave = storage side.
interface instr_register_inf;
    import instr_register_pkg::*;

    logic             load_en;
    logic [IDX_W-1:0] write_index;
    logic [IDX_W-1:0] read_index;
    opcode_t          opcode;
    operand_t         operand_a;
    operand_t         operand_b;
    instruction_t     instruction;

    modport master (
        output load_en,
        output write_index,
        output read_index,
        output opcode,
        output operand_a,
        output operand_b,
        input  instruction
    );

    modport slave (
        input  load_en,
        input  write_index,
        input  read_index,
        input  opcode,
        input  operand_a,
        input  operand_b,
        output instruction
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after rr_ptr,
// wrapping modulo N_REQ. Purely combinational; the pointer lives in the caller.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] winner
);

    always_comb begin
        logic             found;
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
                sum = sum - (PTR_W+1)'(N_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                winner   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Instruction register controller: round-robin write-port sharing among N_REQ
// sources and in-order issue of the oldest slot over valid/ready.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   RUN    | accepting requests and issuing queued slots
//   DRAIN  | halt requested: no new grants, queued slots still issue
//   HALTED | queue empty while halt held; waits for halt to drop
module instr_reg_ctrl
    import instr_register_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                     clk,
    input  logic                     reset_en,
    input  logic [N_REQ-1:0]         req,
    input  instruction_t [N_REQ-1:0] req_instr,
    output logic [N_REQ-1:0]         gnt,
    input  logic                     halt,
    input  logic                     flush,
    output logic                     issue_valid,
    input  logic                     issue_ready,
    output instruction_t             issue_instr,
    output logic                     halted,
    output logic [CNT_W-1:0]         count,
    instr_register_inf.master        io
);

    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    ctrl_state_e      state_q,  state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [RR_W-1:0]  winner;
    logic             grant_en;
    logic             wr_fire;
    logic             pop;

    // reset_en gates the grant directly so a reset mid-burst drops gnt at once.
    assign grant_en = reset_en && (state_q == RUN) && !flush && (count_q != FULL);

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (RR_W)
    ) u_arb (
        .en     (grant_en),
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .gnt    (gnt),
        .winner (winner)
    );

    assign wr_fire     = |gnt;
    assign issue_valid = (count_q != '0) && !flush;
    assign pop         = issue_valid && issue_ready;

    assign io.load_en     = wr_fire;
    assign io.write_index = wr_ptr_q;
    assign io.opcode      = req_instr[winner].opc;
    assign io.operand_a   = req_instr[winner].op_a;
    assign io.operand_b   = req_instr[winner].op_b;
    assign io.read_index  = rd_ptr_q;

    assign issue_instr = io.instruction;
    assign halted      = (state_q == HALTED);
    assign count       = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_d = idx_inc(wr_ptr_q);
                rr_ptr_d = (winner == RR_W'(N_REQ-1)) ? '0 : winner + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = idx_inc(rd_ptr_q);
            end
            if (wr_fire && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !wr_fire) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Using count_d lets a final pop (or a flush) complete the drain in one step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (halt) state_d = DRAIN;
            end
            DRAIN: begin
                if (!halt) begin
                    state_d = RUN;
                end else if (count_d == '0) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!halt) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_en) begin
        if (!reset_en) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset_en) $onehot0(gnt));
    a_count_max:  assert property (@(posedge clk) disable iff (!reset_en) count_q <= FULL);

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Bench for instr_reg_ctrl: models the register storage and checks the controller
// against a queue-based reference model of the request/issue rules.
module tb_instr_reg_ctrl;
    import instr_register_pkg::*;

    localparam int NR = 2;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic                  clk = 1'b0;
    logic                  reset_en = 1'b0;
    logic [NR-1:0]         req = '0;
    instruction_t [NR-1:0] req_instr = '0;
    logic [NR-1:0]         gnt;
    logic                  halt = 1'b0;
    logic                  flush = 1'b0;
    logic                  issue_valid;
    logic                  issue_ready = 1'b0;
    instruction_t          issue_instr;
    logic                  halted;
    logic [CNT_W-1:0]      count;

    instr_register_inf io_if();

    instr_reg_ctrl #(.N_REQ(NR)) dut (
        .clk         (clk),
        .reset_en    (reset_en),
        .req         (req),
        .req_instr   (req_instr),
        .gnt         (gnt),
        .halt        (halt),
        .flush       (flush),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_instr (issue_instr),
        .halted      (halted),
        .count       (count),
        .io          (io_if)
    );

    always #5 clk = ~clk;

    // Storage side of the register, cleared by reset like the real part.
    instruction_t mem [DEPTH];
    always @(posedge clk or negedge reset_en) begin
        if (!reset_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (io_if.load_en) begin
            mem[io_if.write_index] <= {io_if.opcode, io_if.operand_a, io_if.operand_b};
        end
    end
    assign io_if.instruction = mem[io_if.read_index];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of accepted instructions plus slot counters.
    instruction_t mq[$];
    int m_rr, m_mode, m_wr, m_rd;
    logic [NR-1:0] e_gnt;
    int e_win;
    bit e_grant, e_valid, e_halted;
    instruction_t e_instr;
    int e_count;

    function automatic instruction_t rand_instr();
        instruction_t t;
        t.opc  = opcode_t'($urandom_range(0, 7));
        t.op_a = operand_t'($urandom);
        t.op_b = operand_t'($urandom);
        return t;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_rr = 0; m_mode = M_RUN; m_wr = 0; m_rd = 0;
    endfunction

    function automatic void model_eval();
        e_gnt = '0; e_grant = 0; e_win = 0;
        if (m_mode == M_RUN && !flush && mq.size() < DEPTH) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_rr + k) % NR;
                if (!e_grant && req[c]) begin
                    e_grant = 1; e_win = c; e_gnt[c] = 1'b1;
                end
            end
        end
        e_valid  = (mq.size() != 0) && !flush;
        e_instr  = e_valid ? mq[0] : '0;
        e_count  = mq.size();
        e_halted = (m_mode == M_HALTED);
    endfunction

    function automatic void model_update();
        if (flush) begin
            mq.delete(); m_wr = 0; m_rd = 0;
        end else begin
            if (e_valid && issue_ready) begin
                void'(mq.pop_front()); m_rd = (m_rd + 1) % DEPTH;
            end
            if (e_grant) begin
                mq.push_back(req_instr[e_win]);
                m_wr = (m_wr + 1) % DEPTH;
                m_rr = (e_win + 1) % NR;
            end
        end
        case (m_mode)
            M_RUN:    if (halt) m_mode = M_DRAIN;
            M_DRAIN:  if (!halt) m_mode = M_RUN; else if (mq.size() == 0) m_mode = M_HALTED;
            default:  if (!halt) m_mode = M_RUN;
        endcase
    endfunction

    task automatic apply(input logic [NR-1:0] r, input logic h, input logic f, input logic rd);
        req = r; halt = h; flush = f; issue_ready = rd;
        for (int i = 0; i < NR; i++) req_instr[i] = rand_instr();
        #1;
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        if (reset_en) model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_en = 1'b0; req = 2'b11;
        req_instr[0] = rand_instr(); req_instr[1] = rand_instr();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        n_cmp++; if (io_if.load_en !== 1'b0) begin n_bad++; $display("FAIL reset_load_en: got %b want 0", io_if.load_en); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", issue_valid); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        reset_en = 1'b1;
        model_reset();
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) begin
            logic [NR-1:0] want;
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            apply(2'b11, 0, 0, 0);
            n_cmp++; if (gnt !== want) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt, want); end
            n_cmp++; if (io_if.write_index !== IDX_W'(i)) begin n_bad++; $display("FAIL rr_widx[%0d]: got %0d want %0d", i, io_if.write_index, i); end
            adv();
        end
        apply(2'b00, 0, 0, 0);
        n_cmp++; if (count !== CNT_W'(4)) begin n_bad++; $display("FAIL rr_count: got %0d want 4", count); end
        n_cmp++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid: got %b want 1", issue_valid); end
    endtask

    task automatic test_full_wrap();
        while (mq.size() < DEPTH) begin
            apply(2'b11, 0, 0, 0);
            n_cmp++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL fill_gnt: got %b want %b", gnt, e_gnt); end
            adv();
        end
        apply(2'b11, 0, 0, 0);
        n_cmp++; if (count !== CNT_W'(DEPTH)) begin n_bad++; $display("FAIL full_count: got %0d want %0d", count, DEPTH); end
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL full_gnt: got %b want 00", gnt); end
        adv();
        apply(2'b11, 0, 0, 1);
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL full_pop_gnt: got %b want 00", gnt); end
        n_cmp++; if (issue_instr !== e_instr) begin n_bad++; $display("FAIL full_pop_instr: got %h want %h", issue_instr, e_instr); end
        adv();
        apply(2'b11, 0, 0, 0);
        n_cmp++; if (gnt !== e_gnt || gnt === 2'b00) begin n_bad++; $display("FAIL wrap_gnt: got %b want %b", gnt, e_gnt); end
        n_cmp++; if (io_if.write_index !== '0) begin n_bad++; $display("FAIL wrap_widx: got %0d want 0", io_if.write_index); end
        adv();
        for (int i = 0; i < DEPTH; i++) begin
            apply(2'b00, 0, 0, 1);
            n_cmp++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL drain_valid[%0d]: got %b want 1", i, issue_valid); end
            n_cmp++; if (issue_instr !== e_instr) begin n_bad++; $display("FAIL drain_instr[%0d]: got %h want %h", i, issue_instr, e_instr); end
            adv();
        end
        apply(2'b00, 0, 0, 1);
        n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL empty_valid: got %b want 0", issue_valid); end
    endtask

    task automatic test_simultaneous();
        int old_rd, old_wr;
        while (mq.size() < 3) begin apply(2'b01, 0, 0, 0); adv(); end
        apply(2'b01, 0, 0, 1);
        old_rd = m_rd; old_wr = m_wr;
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL sim_gnt: got %b want 01", gnt); end
        n_cmp++; if (io_if.read_index !== IDX_W'(old_rd)) begin n_bad++; $display("FAIL sim_ridx0: got %0d want %0d", io_if.read_index, old_rd); end
        adv();
        apply(2'b00, 0, 0, 0);
        n_cmp++; if (count !== CNT_W'(3)) begin n_bad++; $display("FAIL sim_count: got %0d want 3", count); end
        n_cmp++; if (io_if.read_index !== IDX_W'((old_rd + 1) % DEPTH)) begin n_bad++; $display("FAIL sim_ridx: got %0d want %0d", io_if.read_index, (old_rd + 1) % DEPTH); end
        n_cmp++; if (io_if.write_index !== IDX_W'((old_wr + 1) % DEPTH)) begin n_bad++; $display("FAIL sim_widx: got %0d want %0d", io_if.write_index, (old_wr + 1) % DEPTH); end
    endtask

    task automatic test_halt_drain();
        while (mq.size() > 2) begin apply(2'b00, 0, 0, 1); adv(); end
        apply(2'b00, 1, 0, 1);
        n_cmp++; if (issue_instr !== e_instr) begin n_bad++; $display("FAIL halt_instr0: got %h want %h", issue_instr, e_instr); end
        adv();
        apply(2'b11, 1, 0, 1);
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL drain_gnt: got %b want 00", gnt); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL drain_halted: got %b want 0", halted); end
        n_cmp++; if (issue_instr !== e_instr) begin n_bad++; $display("FAIL halt_instr1: got %h want %h", issue_instr, e_instr); end
        adv();
        apply(2'b11, 1, 0, 0);
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halted_set: got %b want 1", halted); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL halted_count: got %0d want 0", count); end
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL halted_gnt: got %b want 00", gnt); end
        adv();
        apply(2'b11, 0, 0, 0);
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL unhalt_gnt: got %b want 00", gnt); end
        adv();
        apply(2'b11, 0, 0, 0);
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL resume_halted: got %b want 0", halted); end
        n_cmp++; if (gnt !== e_gnt || gnt === 2'b00) begin n_bad++; $display("FAIL resume_gnt: got %b want %b", gnt, e_gnt); end
        adv();
    endtask

    task automatic test_flush();
        while (mq.size() < 5) begin apply(2'b11, 0, 0, 0); adv(); end
        apply(2'b11, 0, 1, 1);
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL flush_gnt: got %b want 00", gnt); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", issue_valid); end
        n_cmp++; if (count !== CNT_W'(5)) begin n_bad++; $display("FAIL flush_count0: got %0d want 5", count); end
        adv();
        apply(2'b00, 0, 0, 1);
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid1: got %b want 0", issue_valid); end
        adv();
    endtask

    task automatic test_reset_mid();
        repeat (3) begin apply(2'b11, 0, 0, 0); adv(); end
        apply(2'b11, 0, 0, 0);
        #2;
        reset_en = 1'b0;
        #1;
        n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL mid_rst_gnt: got %b want 00", gnt); end
        n_cmp++; if (io_if.load_en !== 1'b0) begin n_bad++; $display("FAIL mid_rst_load: got %b want 0", io_if.load_en); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        n_cmp++; if (issue_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", issue_valid); end
        model_reset();
        @(negedge clk);
        reset_en = 1'b1;
        apply(2'b11, 0, 0, 0);
        n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL post_rst_gnt: got %b want 01", gnt); end
        n_cmp++; if (io_if.write_index !== '0) begin n_bad++; $display("FAIL post_rst_widx: got %0d want 0", io_if.write_index); end
        adv();
    endtask

    task automatic test_random();
        logic h;
        h = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) h = ~h;
            apply(NR'($urandom_range(0, 3)), h, ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) != 0));
            n_cmp++; if (gnt !== e_gnt) begin n_bad++; $display("FAIL rnd_gnt[%0d]: got %b want %b", i, gnt, e_gnt); end
            n_cmp++; if (issue_valid !== e_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, issue_valid, e_valid); end
            n_cmp++; if (count !== CNT_W'(e_count)) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, e_count); end
            n_cmp++; if (halted !== e_halted) begin n_bad++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, halted, e_halted); end
            if (e_valid) begin
                n_cmp++; if (issue_instr !== e_instr) begin n_bad++; $display("FAIL rnd_instr[%0d]: got %h want %h", i, issue_instr, e_instr); end
            end
            if (e_grant) begin
                n_cmp++; if (io_if.write_index !== IDX_W'(m_wr)) begin n_bad++; $display("FAIL rnd_widx[%0d]: got %0d want %0d", i, io_if.write_index, m_wr); end
            end
            adv();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_full_wrap();
        test_simultaneous();
        test_halt_drain();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
